serial_mag_comparator: RTL

SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

---
 rtl/serial_mag_comparator.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//
// Bit-serial magnitude comparator. It compares two WIDTH-bit operands A and B
// that arrive one bit pair (a, b) per accepted handshake. The result is kept
// as one-hot flags E (A==B), L (A<B) and G (A>B).
//
// A comparison can be seeded with the result of a neighbouring chunk through
// e_in/l_in/g_in. This lets several instances be cascaded to compare wider
// operands.
//
// Build option: define SERIAL_CMP_LSB_FIRST_EN to receive bits LSB first.
//   - Default (macro undefined), MSB first: the first unequal pair decides the
//     result. The seed acts as the higher-order result, so it dominates
//     whenever it is not "equal".
//   - LSB first: every unequal pair overwrites the result. The seed acts as the
//     lower-order result and is overridden by any unequal pair.
// Interface, FSM, latency and reset behaviour are the same in both builds.
//
// Parameters:
//   WIDTH  bit pairs per comparison (2..32)
//   CNT_W  width of the count output
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   start           begin a new comparison (only looked at in IDLE)
//   e_in/l_in/g_in  cascade seed, captured together with start
//   a, b            current bit pair
//   bit_valid       a/b hold a valid pair
//   bit_ready       a pair is accepted this cycle (RUN only)
//   E, L, G         running/final result, exactly one high
//   done            one-cycle pulse when the result is final
//   busy            high in RUN and DONE
//   count           pairs accepted in the current comparison

module serial_mag_comparator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             e_in,
  input  logic             l_in,
  input  logic             g_in,
  input  logic             a,
  input  logic             b,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic             E,
  output logic             L,
  output logic             G,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             e_q;
  logic             l_q;
  logic             g_q;
  logic [CNT_W-1:0] count_q;

  logic             e_next;
  logic             l_next;
  logic             g_next;
  logic [CNT_W-1:0] count_next;

  logic             accept;
  logic             last_pair;
  logic             seed_valid;

  // A pair is consumed only while running and the source offers one. Nothing
  // on a/b/bit_valid matters in any other state.
  assign accept    = (state == RUN) && bit_valid;

  // The pair that brings the count up to WIDTH finishes the comparison.
  assign last_pair = accept && (count_q == CNT_W'(WIDTH - 1));

  // For three bits, an odd number of ones that is not all three means exactly
  // one is set. Any other seed pattern is treated as "equal".
  assign seed_valid = (e_in ^ l_in ^ g_in) & ~(e_in & l_in & g_in);

  // State register. Reset wins over everything else, so a comparison in flight
  // is simply dropped without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE always lasts exactly one cycle. start is ignored
  // outside IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_pair) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    bit_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      RUN: begin
        bit_ready = 1'b1;
        busy      = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // Result and count update. In IDLE a start loads the seed and clears the
  // count. In RUN each accepted pair bumps the count and may change the
  // result. Otherwise the values hold, so the final result stays visible in
  // IDLE until the next comparison begins.
  always_comb begin
    e_next     = e_q;
    l_next     = l_q;
    g_next     = g_q;
    count_next = count_q;
    case (state)
      IDLE: begin
        if (start) begin
          count_next = '0;
          if (seed_valid) begin
            {e_next, l_next, g_next} = {e_in, l_in, g_in};
          end else begin
            {e_next, l_next, g_next} = 3'b100;
          end
        end
      end
      RUN: begin
        if (accept) begin
          count_next = count_q + CNT_W'(1);
`ifdef SERIAL_CMP_LSB_FIRST_EN
          // Later pairs are more significant, so any difference replaces
          // whatever was decided so far.
          if (a && !b) begin
            {e_next, l_next, g_next} = 3'b001;
          end else if (!a && b) begin
            {e_next, l_next, g_next} = 3'b010;
          end
`else
          // Earlier pairs are more significant, so only an operand pair that
          // is still equal can be decided by this bit.
          if (e_q && a && !b) begin
            {e_next, l_next, g_next} = 3'b001;
          end else if (e_q && !a && b) begin
            {e_next, l_next, g_next} = 3'b010;
          end
`endif
        end
      end
      default: ;
    endcase
  end

  // Result/count registers. Reset state is "equal" with nothing accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q     <= 1'b1;
      l_q     <= 1'b0;
      g_q     <= 1'b0;
      count_q <= '0;
    end else begin
      e_q     <= e_next;
      l_q     <= l_next;
      g_q     <= g_next;
      count_q <= count_next;
    end
  end

  assign E     = e_q;
  assign L     = l_q;
  assign G     = g_q;
  assign count = count_q;

endmodule
